// File: rtl/vga_pkg.sv
// Shared raster timing definitions for the VGA timing generator.
// Holds the standard mode geometries, the default counter width, the
// region encoding used by the axis counters and the axis-total helper.
package vga_pkg;

   // Default counter / coordinate width (covers totals up to 2048).
   localparam int unsigned VGA_CNT_W = 11;

   // One axis of raster geometry, in pixels (horizontal) or lines (vertical).
   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } axis_timing_t;

   // 640x480@60, 25 MHz pixel clock, negative sync polarity.
   localparam axis_timing_t VGA_640X480_H   = '{active: 640, fp: 16, sync: 96,  bp: 48};
   localparam axis_timing_t VGA_640X480_V   = '{active: 480, fp: 10, sync: 2,   bp: 33};
   localparam bit           VGA_640X480_POL = 1'b0;

   // 800x600@60, 40 MHz pixel clock, positive sync polarity.
   localparam axis_timing_t VGA_800X600_H   = '{active: 800, fp: 40, sync: 128, bp: 88};
   localparam axis_timing_t VGA_800X600_V   = '{active: 600, fp: 1,  sync: 4,   bp: 23};
   localparam bit           VGA_800X600_POL = 1'b1;

   // Region of an axis position; order along the axis is fixed.
   typedef enum logic [1:0] {
      REG_ACTIVE = 2'd0,
      REG_FP     = 2'd1,
      REG_SYNC   = 2'd2,
      REG_BP     = 2'd3
   } region_t;

   // Total positions along one axis.
   function automatic int unsigned axis_total(
      input int unsigned active,
      input int unsigned fp,
      input int unsigned sync,
      input int unsigned bp
   );
      return active + fp + sync + bp;
   endfunction

   // First position of the sync region along one axis.
   function automatic int unsigned axis_sync_start(
      input int unsigned active,
      input int unsigned fp
   );
      return active + fp;
   endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Generic raster axis counter: counts 0..TOTAL-1 on each Inc and wraps.
// Decodes the current position into active / front porch / sync / back
// porch and exposes Active and Sync flags plus a combinational Wrap that
// is high on the Inc cycle that returns the count to zero.
module vga_sync_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE  = VGA_640X480_H.active,
   parameter int unsigned FP      = VGA_640X480_H.fp,
   parameter int unsigned SYNC    = VGA_640X480_H.sync,
   parameter int unsigned BP      = VGA_640X480_H.bp,
   parameter int unsigned CNT_W   = VGA_CNT_W,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             Clk,
   input  logic             RstN,
   input  logic             Inc,
   output logic [CNT_W-1:0] Cnt,
   output logic             Wrap,
   output logic             Active,
   output logic             Sync
);

   localparam int unsigned      TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
   localparam int unsigned      SYNC_START = axis_sync_start(ACTIVE, FP);
   localparam int unsigned      BP_START   = SYNC_START + SYNC;
   localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] PRESET     = CNT_W'(RST_VAL);

   if (longint'(TOTAL) > (longint'(1) << CNT_W)) begin : g_chk_width
      $error("vga_sync_counter: axis total does not fit in CNT_W bits");
   end
   if (RST_VAL >= TOTAL) begin : g_chk_preset
      $error("vga_sync_counter: RST_VAL must lie inside the axis");
   end

   region_t     region;
   logic        at_last;
   int unsigned cnt_i;

   // Classify the current position into its raster region.
   always_comb begin
      cnt_i = 32'(Cnt);
      if (cnt_i < ACTIVE) begin
         region = REG_ACTIVE;
      end else if (cnt_i < SYNC_START) begin
         region = REG_FP;
      end else if (cnt_i < BP_START) begin
         region = REG_SYNC;
      end else begin
         region = REG_BP;
      end
   end

   // Region flags and wrap strobe derived from the current position.
   always_comb begin
      at_last = (Cnt == LAST);
      Wrap    = Inc && at_last;
      Active  = (region == REG_ACTIVE);
      Sync    = (region == REG_SYNC);
   end

   // Modulo-TOTAL position register, preset to RST_VAL on reset.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         Cnt <= PRESET;
      end else if (Inc) begin
         Cnt <= at_last ? '0 : Cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator for the pixel clock domain.
// Produces registered HSync/VSync, DataEn, active-pixel coordinates and
// line/frame start strobes, all from the same counter snapshot.
// Optional macro VGA_TIMING_PREFETCH_EN adds FetchEn/FetchX/FetchY, which
// show the DataEn/PixX/PixY values FETCH_LEAD cycles ahead of time.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = VGA_640X480_H.active,
   parameter int unsigned H_FP       = VGA_640X480_H.fp,
   parameter int unsigned H_SYNC     = VGA_640X480_H.sync,
   parameter int unsigned H_BP       = VGA_640X480_H.bp,
   parameter int unsigned V_ACTIVE   = VGA_640X480_V.active,
   parameter int unsigned V_FP       = VGA_640X480_V.fp,
   parameter int unsigned V_SYNC     = VGA_640X480_V.sync,
   parameter int unsigned V_BP       = VGA_640X480_V.bp,
   parameter bit          H_SYNC_POL = VGA_640X480_POL,
   parameter bit          V_SYNC_POL = VGA_640X480_POL,
   parameter int unsigned CNT_W      = VGA_CNT_W,
   parameter int unsigned FETCH_LEAD = 2
) (
   input  logic             Clk,
   input  logic             RstN,
   output logic             HSync,
   output logic             VSync,
   output logic             DataEn,
   output logic [CNT_W-1:0] PixX,
   output logic [CNT_W-1:0] PixY,
   output logic             LineStart,
   output logic             FrameStart
`ifdef VGA_TIMING_PREFETCH_EN
   ,
   output logic             FetchEn,
   output logic [CNT_W-1:0] FetchX,
   output logic [CNT_W-1:0] FetchY
`endif
);

   localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_region
      $error("vga_timing: every active/porch/sync region must be at least 1");
   end
   if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
       longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_chk_total
      $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2**CNT_W");
   end
   if (FETCH_LEAD >= H_FP + H_SYNC + H_BP) begin : g_chk_lead
      $error("vga_timing: FETCH_LEAD must be shorter than the horizontal blanking");
   end

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_wrap;
   logic             v_wrap;
   logic             h_active;
   logic             v_active;
   logic             h_sync;
   logic             v_sync;
   logic             unused_sigs;

   vga_sync_counter #(
      .ACTIVE  (H_ACTIVE),
      .FP      (H_FP),
      .SYNC    (H_SYNC),
      .BP      (H_BP),
      .CNT_W   (CNT_W),
      .RST_VAL (0)
   ) u_h_cnt (
      .Clk    (Clk),
      .RstN   (RstN),
      .Inc    (1'b1),
      .Cnt    (h_cnt),
      .Wrap   (h_wrap),
      .Active (h_active),
      .Sync   (h_sync)
   );

   vga_sync_counter #(
      .ACTIVE  (V_ACTIVE),
      .FP      (V_FP),
      .SYNC    (V_SYNC),
      .BP      (V_BP),
      .CNT_W   (CNT_W),
      .RST_VAL (0)
   ) u_v_cnt (
      .Clk    (Clk),
      .RstN   (RstN),
      .Inc    (h_wrap),
      .Cnt    (v_cnt),
      .Wrap   (v_wrap),
      .Active (v_active),
      .Sync   (v_sync)
   );

   // Register every output from the same (h_cnt, v_cnt) snapshot.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         HSync      <= ~H_SYNC_POL;
         VSync      <= ~V_SYNC_POL;
         DataEn     <= 1'b0;
         PixX       <= '0;
         PixY       <= '0;
         LineStart  <= 1'b0;
         FrameStart <= 1'b0;
      end else begin
         HSync      <= h_sync ? H_SYNC_POL : ~H_SYNC_POL;
         VSync      <= v_sync ? V_SYNC_POL : ~V_SYNC_POL;
         DataEn     <= h_active && v_active;
         PixX       <= h_active ? h_cnt : '0;
         PixY       <= v_active ? v_cnt : '0;
         LineStart  <= (h_cnt == '0);
         FrameStart <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

`ifdef VGA_TIMING_PREFETCH_EN
   logic [CNT_W-1:0] f_h_cnt;
   logic [CNT_W-1:0] f_v_cnt;
   logic             f_h_wrap;
   logic             f_v_wrap;
   logic             f_h_active;
   logic             f_v_active;
   logic             f_h_sync;
   logic             f_v_sync;

   // Lead counter pair: starts FETCH_LEAD pixels into row 0, so line and
   // frame carries happen exactly FETCH_LEAD cycles before the main pair.
   vga_sync_counter #(
      .ACTIVE  (H_ACTIVE),
      .FP      (H_FP),
      .SYNC    (H_SYNC),
      .BP      (H_BP),
      .CNT_W   (CNT_W),
      .RST_VAL (FETCH_LEAD)
   ) u_fh_cnt (
      .Clk    (Clk),
      .RstN   (RstN),
      .Inc    (1'b1),
      .Cnt    (f_h_cnt),
      .Wrap   (f_h_wrap),
      .Active (f_h_active),
      .Sync   (f_h_sync)
   );

   vga_sync_counter #(
      .ACTIVE  (V_ACTIVE),
      .FP      (V_FP),
      .SYNC    (V_SYNC),
      .BP      (V_BP),
      .CNT_W   (CNT_W),
      .RST_VAL (0)
   ) u_fv_cnt (
      .Clk    (Clk),
      .RstN   (RstN),
      .Inc    (f_h_wrap),
      .Cnt    (f_v_cnt),
      .Wrap   (f_v_wrap),
      .Active (f_v_active),
      .Sync   (f_v_sync)
   );

   // Register the fetch view with the same one-cycle latency as the main view.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         FetchEn <= 1'b0;
         FetchX  <= '0;
         FetchY  <= '0;
      end else begin
         FetchEn <= f_h_active && f_v_active;
         FetchX  <= f_h_active ? f_h_cnt : '0;
         FetchY  <= f_v_active ? f_v_cnt : '0;
      end
   end

   // Frame wrap and lead-counter sync flags have no consumer.
   always_comb begin
      unused_sigs = ^{v_wrap, f_v_wrap, f_h_sync, f_v_sync};
   end
`else
   // Frame wrap has no consumer.
   always_comb begin
      unused_sigs = v_wrap;
   end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: default 640x480 geometry (reset and
// line timing), a tiny positive-polarity geometry compared every cycle, and
// a medium geometry for frame timing, mid-frame reset and prefetch outputs.
module tb_vga_timing;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [10:0] px;
      logic [10:0] py;
      logic        ls;
      logic        fs;
   } out_t;

   typedef struct packed {
      logic        de;
      logic [10:0] x;
      logic [10:0] y;
   } fetch_t;

   typedef struct {
      int unsigned k;
      out_t        exp;
   } vec_t;

   logic clk;
   logic rst_d, rst_t, rst_m;

   logic        d_hs, d_vs, d_de, d_ls, d_fs;
   logic [10:0] d_px, d_py;
   logic        t_hs, t_vs, t_de, t_ls, t_fs;
   logic [10:0] t_px, t_py;
   logic        m_hs, m_vs, m_de, m_ls, m_fs;
   logic [10:0] m_px, m_py;

   out_t got_d, got_t, got_m;
   assign got_d = {d_hs, d_vs, d_de, d_px, d_py, d_ls, d_fs};
   assign got_t = {t_hs, t_vs, t_de, t_px, t_py, t_ls, t_fs};
   assign got_m = {m_hs, m_vs, m_de, m_px, m_py, m_ls, m_fs};

`ifdef VGA_TIMING_PREFETCH_EN
   logic        d_fe, t_fe, m_fe;
   logic [10:0] d_fx, d_fy, t_fx, t_fy, m_fx, m_fy;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_timing u_dut_d (
      .Clk(clk), .RstN(rst_d), .HSync(d_hs), .VSync(d_vs), .DataEn(d_de),
      .PixX(d_px), .PixY(d_py), .LineStart(d_ls), .FrameStart(d_fs)
`ifdef VGA_TIMING_PREFETCH_EN
      , .FetchEn(d_fe), .FetchX(d_fx), .FetchY(d_fy)
`endif
   );

   vga_timing #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(11), .FETCH_LEAD(2)
   ) u_dut_t (
      .Clk(clk), .RstN(rst_t), .HSync(t_hs), .VSync(t_vs), .DataEn(t_de),
      .PixX(t_px), .PixY(t_py), .LineStart(t_ls), .FrameStart(t_fs)
`ifdef VGA_TIMING_PREFETCH_EN
      , .FetchEn(t_fe), .FetchX(t_fx), .FetchY(t_fy)
`endif
   );

   vga_timing #(
      .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_W(11), .FETCH_LEAD(2)
   ) u_dut_m (
      .Clk(clk), .RstN(rst_m), .HSync(m_hs), .VSync(m_vs), .DataEn(m_de),
      .PixX(m_px), .PixY(m_py), .LineStart(m_ls), .FrameStart(m_fs)
`ifdef VGA_TIMING_PREFETCH_EN
      , .FetchEn(m_fe), .FetchX(m_fx), .FetchY(m_fy)
`endif
   );

   // Expected outputs for raster position p counted from (0,0).
   function automatic out_t model(input int unsigned p,
                                  input int unsigned ha, input int unsigned hf,
                                  input int unsigned hw, input int unsigned hb,
                                  input int unsigned va, input int unsigned vf,
                                  input int unsigned vw, input int unsigned vb,
                                  input bit hpol, input bit vpol);
      out_t        r;
      int unsigned ht, vt, h, v;
      ht   = ha + hf + hw + hb;
      vt   = va + vf + vw + vb;
      h    = p % ht;
      v    = (p / ht) % vt;
      r.hs = (h >= ha + hf && h < ha + hf + hw) ? hpol : !hpol;
      r.vs = (v >= va + vf && v < va + vf + vw) ? vpol : !vpol;
      r.de = (h < ha) && (v < va);
      r.px = (h < ha) ? 11'(h) : 11'd0;
      r.py = (v < va) ? 11'(v) : 11'd0;
      r.ls = (h == 0);
      r.fs = (h == 0) && (v == 0);
      return r;
   endfunction

   function automatic out_t model_d(input int unsigned p);
      return model(p, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
   endfunction
   function automatic out_t model_t(input int unsigned p);
      return model(p, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
   endfunction
   function automatic out_t model_m(input int unsigned p);
      return model(p, 40, 4, 8, 4, 30, 2, 2, 3, 1'b0, 1'b0);
   endfunction
   function automatic fetch_t fetch_of(input out_t o);
      return {o.de, o.px, o.py};
   endfunction

   task automatic check_out(input string name, input out_t act, input out_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b, expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                    name, act.hs, act.vs, act.de, act.px, act.py, act.ls, act.fs,
                    exp.hs, exp.vs, exp.de, exp.px, exp.py, exp.ls, exp.fs);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_fetch(input string name, input fetch_t act, input fetch_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got en=%b x=%0d y=%0d, expected en=%b x=%0d y=%0d",
                    name, act.de, act.x, act.y, exp.de, exp.x, exp.y);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   vec_t        tbl[12];
   out_t        rst_neg, rst_pos;
   int unsigned cur;
   int          found, de_cnt, sync_cnt, first_sync, first_de_low, ls_between, px_err, fs_between, ls_at_sync;

   initial begin
      rst_neg = {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
      rst_pos = {1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
      //            k       hs    vs    de    px       py     ls    fs
      tbl[0]  = '{1,    {1'b1, 1'b1, 1'b1, 11'd0,   11'd0, 1'b1, 1'b1}};
      tbl[1]  = '{2,    {1'b1, 1'b1, 1'b1, 11'd1,   11'd0, 1'b0, 1'b0}};
      tbl[2]  = '{640,  {1'b1, 1'b1, 1'b1, 11'd639, 11'd0, 1'b0, 1'b0}};
      tbl[3]  = '{641,  {1'b1, 1'b1, 1'b0, 11'd0,   11'd0, 1'b0, 1'b0}};
      tbl[4]  = '{656,  {1'b1, 1'b1, 1'b0, 11'd0,   11'd0, 1'b0, 1'b0}};
      tbl[5]  = '{657,  {1'b0, 1'b1, 1'b0, 11'd0,   11'd0, 1'b0, 1'b0}};
      tbl[6]  = '{752,  {1'b0, 1'b1, 1'b0, 11'd0,   11'd0, 1'b0, 1'b0}};
      tbl[7]  = '{753,  {1'b1, 1'b1, 1'b0, 11'd0,   11'd0, 1'b0, 1'b0}};
      tbl[8]  = '{800,  {1'b1, 1'b1, 1'b0, 11'd0,   11'd0, 1'b0, 1'b0}};
      tbl[9]  = '{801,  {1'b1, 1'b1, 1'b1, 11'd0,   11'd1, 1'b1, 1'b0}};
      tbl[10] = '{802,  {1'b1, 1'b1, 1'b1, 11'd1,   11'd1, 1'b0, 1'b0}};
      tbl[11] = '{1606, {1'b1, 1'b1, 1'b1, 11'd5,   11'd2, 1'b0, 1'b0}};

      rst_d = 1'b0; rst_t = 1'b0; rst_m = 1'b0;
      repeat (5) @(negedge clk);
      check_out("reset_default", got_d, rst_neg);
      check_out("reset_tiny_pos_pol", got_t, rst_pos);
      check_out("reset_medium", got_m, rst_neg);
`ifdef VGA_TIMING_PREFETCH_EN
      check_fetch("reset_fetch", {m_fe, m_fx, m_fy}, '0);
`endif

      // Default geometry: hand-computed points along the first lines.
      rst_d = 1'b1;
      cur   = 0;
      for (int i = 0; i < 12; i++) begin
         repeat (tbl[i].k - cur) tick();
         cur = tbl[i].k;
         check_out($sformatf("vec%0d_k%0d", i, tbl[i].k), got_d, tbl[i].exp);
`ifdef VGA_TIMING_PREFETCH_EN
         check_fetch($sformatf("vec%0d_fetch", i), {d_fe, d_fx, d_fy}, fetch_of(model_d(tbl[i].k + 1)));
`endif
      end

      // Default geometry: one full line measured from LineStart.
      found = 0;
      for (int i = 0; i < 801 && found == 0; i++) begin
         tick();
         if (d_ls) found = 1;
      end
      check_int("line_start_seen", found, 1);
      de_cnt = 0; sync_cnt = 0; first_sync = -1; first_de_low = -1; ls_between = 0; px_err = 0;
      for (int i = 0; i < 800; i++) begin
         if (d_de) de_cnt++;
         else if (first_de_low < 0) first_de_low = i;
         if (!d_hs) begin
            sync_cnt++;
            if (first_sync < 0) first_sync = i;
         end
         if (i > 0 && d_ls) ls_between++;
         if (d_px !== ((i < 640) ? 11'(i) : 11'd0)) px_err++;
         tick();
      end
      check_int("line_de_cycles", de_cnt, 640);
      check_int("line_de_end", first_de_low, 640);
      check_int("line_hsync_cycles", sync_cnt, 96);
      check_int("line_hsync_start", first_sync, 656);
      check_int("line_extra_linestart", ls_between, 0);
      check_int("line_pixx_errors", px_err, 0);
      check_int("line_period_800", int'(d_ls), 1);

      // Tiny geometry: three frames, every cycle against the model.
      rst_t = 1'b1;
      for (int i = 0; i < 144; i++) begin
         tick();
         check_out($sformatf("tiny_p%0d", i), got_t, model_t(i));
`ifdef VGA_TIMING_PREFETCH_EN
         check_fetch($sformatf("tiny_fetch_p%0d", i), {t_fe, t_fx, t_fy}, fetch_of(model_t(i + 2)));
`endif
      end

      // Medium geometry: one full frame with frame-level measurements.
      rst_m = 1'b1;
      de_cnt = 0; sync_cnt = 0; first_sync = -1; fs_between = 0; ls_at_sync = 0;
      for (int i = 0; i < 2072; i++) begin
         tick();
         check_out($sformatf("med_p%0d", i), got_m, model_m(i));
`ifdef VGA_TIMING_PREFETCH_EN
         check_fetch($sformatf("med_fetch_p%0d", i), {m_fe, m_fx, m_fy}, fetch_of(model_m(i + 2)));
`endif
         if (m_de) de_cnt++;
         if (!m_vs) begin
            sync_cnt++;
            if (first_sync < 0) begin
               first_sync = i;
               ls_at_sync = int'(m_ls);
            end
         end
         if (i > 0 && m_fs) fs_between++;
      end
      tick();
      check_int("frame_period_2072", int'(m_fs), 1);
      check_int("frame_extra_framestart", fs_between, 0);
      check_int("frame_de_cycles", de_cnt, 1200);
      check_int("frame_vsync_cycles", sync_cnt, 112);
      check_int("frame_vsync_start", first_sync, 1792);
      check_int("frame_vsync_on_linestart", ls_at_sync, 1);

      // Medium geometry: asynchronous reset at line 20 pixel 13.
      repeat (3205 - 2072) tick();
      check_out("pre_reset_pos", got_m, model_m(3205));
      #2 rst_m = 1'b0;
      #1 check_out("async_reset_immediate", got_m, rst_neg);
`ifdef VGA_TIMING_PREFETCH_EN
      check_fetch("async_reset_fetch", {m_fe, m_fx, m_fy}, '0);
`endif
      repeat (2) tick();
      check_out("reset_held", got_m, rst_neg);
      rst_m = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         check_out($sformatf("restart_p%0d", i), got_m, model_m(i));
`ifdef VGA_TIMING_PREFETCH_EN
         check_fetch($sformatf("restart_fetch_p%0d", i), {m_fe, m_fx, m_fy}, fetch_of(model_m(i + 2)));
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator clocked by the pixel clock from the DCM clock source.
- Produces HSync/VSync, a data-enable, active-pixel coordinates and line/frame strobes for the downstream pixel fetch and output stages.
- Fully parameterised porch/sync geometry. Default is 640x480@60 (25 MHz pixel clock).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of HSync
- V_SYNC_POL, 0, asserted level of VSync
- CNT_W, 11, counter/coordinate width
- FETCH_LEAD, 2, prefetch lead in cycles; used only with the optional feature

Ports:
- Clk  in  1  pixel clock (DCM output via BUFG)
- RstN  in  1  reset
- HSync  out  1  horizontal sync at H_SYNC_POL when asserted
- VSync  out  1  vertical sync at V_SYNC_POL when asserted
- DataEn  out  1  high in the active region (HCnt<H_ACTIVE and VCnt<V_ACTIVE)
- PixX  out  CNT_W  HCnt when HCnt<H_ACTIVE, else 0
- PixY  out  CNT_W  VCnt when VCnt<V_ACTIVE, else 0
- LineStart  out  1  one-cycle pulse when HCnt==0
- FrameStart  out  1  one-cycle pulse when HCnt==0 and VCnt==0

Interface decision: one clock (Clk); reset RstN is asynchronous and active-low.

Behaviour:
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL likewise (525).
- Region order on each axis: active, front porch, sync, back porch.
- HCnt advances every Clk edge, 0..H_TOTAL-1, then wraps to 0.
- VCnt advances only on the HCnt wrap edge, 0..V_TOTAL-1, then wraps.
- Last pixel of frame (HCnt=H_TOTAL-1, VCnt=V_TOTAL-1): both counters wrap to 0 on the same edge.
- HSync is asserted for HCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751 by default.
- VSync is asserted for VCnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491 by default. VSync changes aligned with line boundaries.
- All outputs are registered: one cycle latency from counter state. All outputs are mutually aligned (same counter snapshot).
- RstN low, asynchronously and immediately, including mid-frame:
  - HCnt=VCnt=0
  - HSync=~H_SYNC_POL, VSync=~V_SYNC_POL
  - DataEn=0, PixX=PixY=0, LineStart=FrameStart=0
- First edge after RstN release: outputs reflect (0,0), so DataEn=1, LineStart=1, FrameStart=1, PixX=PixY=0. Counters go to (1,0).
- No handshake. The stream is free-running; downstream must accept one pixel per cycle while DataEn=1.
- Elaboration check (error on failure):
  - every region parameter ≥1
  - H_TOTAL and V_TOTAL ≤ 2^CNT_W
  - FETCH_LEAD < H_FP+H_SYNC+H_BP

Optional Feature:
- Macro: VGA_TIMING_PREFETCH_EN.
- With the macro defined, extra outputs FetchEn(1), FetchX(CNT_W) and FetchY(CNT_W) are added.
  - They carry the DataEn/PixX/PixY values the main outputs will show exactly FETCH_LEAD cycles later.
  - They are generated from a second counter pair preset at reset to position FETCH_LEAD (row 0).
  - Wrap and carry are handled identically: a lead crossing the line end carries into the next line, and a lead crossing the frame end wraps to line 0.
  - Fetch outputs reset to 0.
- Without the macro, these ports and their logic are absent, and the main outputs are unchanged bit-for-bit.

Decomposition:
- Shared package vga_pkg:
  - timing constant sets for 640x480@60 and 800x600@60
  - CNT_W default
  - function computing axis totals
- One sub-module, vga_sync_counter:
  - generic modulo counter with ACTIVE/FP/SYNC/BP parameters
  - inputs: Clk, RstN, Inc; outputs: Cnt, Wrap, Active, Sync
- It is instantiated for H (Inc=1) and V (Inc=H Wrap), and twice more when VGA_TIMING_PREFETCH_EN is defined.

Test Plan:
- Reset check: hold RstN low 5 cycles with defaults -> HSync=1, VSync=1, DataEn=0, PixX=PixY=0, pulses 0. First edge after release -> DataEn=1, FrameStart=1.
- Line timing: count cycles from LineStart.
  - LineStart period is 800.
  - DataEn high for cycles 0..639 of the line; PixX 0..639 then 0.
  - HSync low for cycles 656..751.
- Frame timing:
  - FrameStart period is 420000 cycles.
  - 307200 DataEn cycles per frame.
  - VSync low exactly for lines 490..491 (1600 cycles), starting with the LineStart of line 490.
- Tiny geometry (H 4/1/2/1, V 3/1/1/1, POL=1): run 3 frames and compare every cycle against a reference model. Covers the simultaneous H/V wrap and positive polarity.
- Mid-frame reset: assert RstN at line 300 pixel 123 -> all outputs go to reset values without waiting for Clk. After release, the sequence restarts at (0,0) identically to power-up.
- Prefetch (VGA_TIMING_PREFETCH_EN, FETCH_LEAD=2):
  - FetchEn/FetchX/FetchY equal DataEn/PixX/PixY delayed by -2 cycles at every cycle.
  - Across line 479→480 and frame wrap, FetchX=0, FetchY=0 appear 2 cycles before FrameStart.
